bram_dp: RTL and testbench

BRAM_DP -- requirements
Module: bram_dp

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_rd_pipe.sv | 40 ++++
 rtl/bram_dp.sv | 125 ++++++++++++
 tb/tb_bram_dp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and legal parameter values for the dual-port block RAM.
// Imported by bram_dp and bram_rd_pipe.
package bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

  localparam int WR_READ_FIRST  = 0;
  localparam int WR_WRITE_FIRST = 1;

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-latency pipeline: valid and data stages, RD_LAT deep.
// Data only advances with valid, so the output holds between pulses.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = RD_LAT_1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [RD_LAT-1:0] r_v;
  logic [DATA_W-1:0] r_d [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int i = 0; i < RD_LAT; i++)
        r_d[i] <= '0;
    end else begin
      r_v[0] <= i_valid;
      if (i_valid)
        r_d[0] <= i_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        if (r_v[i-1])
          r_d[i] <= r_d[i-1];
      end
    end
  end

  assign o_valid = r_v[RD_LAT-1];
  assign o_data  = r_d[RD_LAT-1];

endmodule

// File: rtl/bram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read.
// After reset a sweep zeroes every word before requests are accepted.
module bram_dp
  import bram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16384,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int RD_LAT  = RD_LAT_1,
  parameter int WR_MODE = WR_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic                b_ready,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  if ((RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) ||
      (WR_MODE != WR_READ_FIRST && WR_MODE != WR_WRITE_FIRST))
  begin : g_bad_param
    $error("bram_dp: illegal RD_LAT or WR_MODE");
  end

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_a_inr, w_b_inr;
  logic              w_a_wr, w_a_rd, w_b_rd;
  logic [DATA_W-1:0] w_a_word, w_b_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      CLEAR: begin
        w_cnt_nx = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST) begin
          w_state_nx = RUN;
          w_cnt_nx   = '0;
        end
      end
      RUN: ;
      default: w_state_nx = CLEAR;
    endcase
  end

  assign w_run     = (r_state == RUN);
  assign init_done = w_run;
  assign a_ready   = w_run;
  assign b_ready   = w_run;

  // Non-power-of-2 depths leave a hole at the top of the address space
  assign w_a_inr = (32'(a_addr) < 32'(DEPTH));
  assign w_b_inr = (32'(b_addr) < 32'(DEPTH));

  assign w_a_wr = a_req & w_run & a_we & w_a_inr;
  assign w_a_rd = a_req & w_run & ~a_we;
  assign w_b_rd = b_req & w_run;

  // Reads sample before the edge, so a same-cycle A write is not visible
  assign w_a_word = w_a_inr ? r_mem[a_addr] : '0;
  assign w_b_word = w_b_inr ? r_mem[b_addr] : '0;

  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_a_wr) begin
      for (int i = 0; i < NB; i++)
        if (a_be[i])
          r_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_a_rd),
    .i_data  (w_a_word),
    .o_valid (a_rvalid),
    .o_data  (a_rdata)
  );

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_b_rd),
    .i_data  (w_b_word),
    .o_valid (b_rvalid),
    .o_data  (b_rdata)
  );

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench: u0 is DEPTH=16/RD_LAT=1, u1 is DEPTH=12/RD_LAT=2.
// Both see the same stimulus; expectations are hand-computed constants.
module tb_bram_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req, a_we, b_req;
  logic [3:0]  a_be, a_addr, b_addr;
  logic [31:0] a_wdata;

  logic        id0, ar0, arv0, br0, brv0;
  logic [31:0] ard0, brd0;
  logic        id1, ar1, arv1, br1, brv1;
  logic [31:0] ard1, brd1;

  int checks = 0;
  int failures = 0;
  int n0, n1;

  always #5 clk = ~clk;

  bram_dp #(.DATA_W(32), .DEPTH(16), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .init_done(id0),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ready(ar0), .a_rdata(ard0), .a_rvalid(arv0),
    .b_req(b_req), .b_addr(b_addr), .b_ready(br0), .b_rdata(brd0),
    .b_rvalid(brv0)
  );

  bram_dp #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .init_done(id1),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ready(ar1), .a_rdata(ard1), .a_rvalid(arv1),
    .b_req(b_req), .b_addr(b_addr), .b_ready(br1), .b_rdata(brd1),
    .b_rvalid(brv1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_be = 4'h0; a_addr = 4'h0;
    a_wdata = 32'h0; b_req = 0; b_addr = 4'h0;
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [3:0] be,
                      input logic [31:0] d);
    a_req = 1; a_we = 1; a_be = be; a_addr = ad; a_wdata = d;
  endtask

  task automatic a_rd(input logic [3:0] ad);
    a_req = 1; a_we = 0; a_be = 4'h0; a_addr = ad;
  endtask

  // Count cycles from reset release until each init_done rises
  task automatic measure_init(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 1) chk("clear_a_ready", {31'b0, ar0}, 32'd0);
      if (id0 && c0 == 0) c0 = n;
      if (id1 && c1 == 0) c1 = n;
    end
  endtask

  initial begin
    idle();
    tick(); tick();
    chk("rst_init_done", {31'b0, id0}, 32'd0);
    chk("rst_ready", {30'b0, ar0, br0}, 32'd0);
    chk("rst_rvalid", {28'b0, arv0, brv0, arv1, brv1}, 32'd0);
    chk("rst_a_rdata", ard0, 32'h0);
    chk("rst_b_rdata", brd1, 32'h0);

    rst = 1;
    measure_init(n0, n1);
    chk("init_cycles_d16", n0, 32'd16);
    chk("init_cycles_d12", n1, 32'd12);
    chk("run_ready", {28'b0, ar0, br0, ar1, br1}, 32'hF);

    for (int i = 0; i < 16; i++) begin
      a_rd(4'(i)); b_req = 1; b_addr = 4'(i);
      tick();
      chk("clr_a_rvalid", {31'b0, arv0}, 32'd1);
      chk("clr_a_rdata", ard0, 32'h0);
      chk("clr_b_rdata", brd0, 32'h0);
    end
    idle();
    tick();
    chk("clr_a_rvalid_end", {31'b0, arv0}, 32'd0);
    chk("clr_lat2_last", {31'b0, arv1}, 32'd1);
    tick();

    a_wr(4'd5, 4'hF, 32'hDEADBEEF);
    tick();
    chk("wr_no_rvalid", {31'b0, arv0}, 32'd0);
    a_wr(4'd5, 4'h3, 32'h00001234);
    tick();
    a_rd(4'd5);
    tick();
    chk("be_rvalid", {31'b0, arv0}, 32'd1);
    chk("be_merge", ard0, 32'hDEAD1234);
    idle();
    tick();
    chk("rvalid_pulse", {31'b0, arv0}, 32'd0);
    chk("rdata_hold", ard0, 32'hDEAD1234);
    chk("be_merge_lat2", ard1, 32'hDEAD1234);
    a_wr(4'd5, 4'h0, 32'hFFFFFFFF);
    tick();
    a_rd(4'd5);
    tick();
    chk("be_zero_noop", ard0, 32'hDEAD1234);
    idle();
    tick(); tick();

    a_wr(4'd1, 4'hF, 32'h000000A1); tick();
    a_wr(4'd2, 4'hF, 32'h000000A2); tick();
    a_wr(4'd3, 4'hF, 32'h000000A3); tick();
    a_rd(4'd1); tick();
    chk("lat2_c1_idle", {31'b0, arv1}, 32'd0);
    chk("lat1_c1", ard0, 32'h000000A1);
    a_rd(4'd2); tick();
    chk("lat2_c2_v", {31'b0, arv1}, 32'd1);
    chk("lat2_c2_d", ard1, 32'h000000A1);
    a_rd(4'd3); tick();
    chk("lat2_c3_v", {31'b0, arv1}, 32'd1);
    chk("lat2_c3_d", ard1, 32'h000000A2);
    idle(); tick();
    chk("lat2_c4_v", {31'b0, arv1}, 32'd1);
    chk("lat2_c4_d", ard1, 32'h000000A3);
    tick();
    chk("lat2_c5_v", {31'b0, arv1}, 32'd0);

    a_wr(4'd7, 4'hF, 32'h11111111); tick();
    a_wr(4'd7, 4'hF, 32'h55AA55AA); b_req = 1; b_addr = 4'd7;
    tick();
    chk("coll_b_v", {31'b0, brv0}, 32'd1);
    chk("coll_b_old", brd0, 32'h11111111);
    a_req = 0;
    tick();
    chk("coll_b_new", brd0, 32'h55AA55AA);
    chk("coll_b_old_lat2", brd1, 32'h11111111);
    b_req = 0;
    tick();
    chk("coll_b_new_lat2", brd1, 32'h55AA55AA);

    a_wr(4'd13, 4'hF, 32'hCAFEF00D); tick();
    a_rd(4'd13); tick();
    chk("oor_in_range", ard0, 32'hCAFEF00D);
    idle(); tick();
    chk("oor_rvalid", {31'b0, arv1}, 32'd1);
    chk("oor_rdata", ard1, 32'h0);

    a_rd(4'd5); tick();
    rst = 0;
    idle();
    #1;
    chk("rst_run_rvalid", {28'b0, arv0, brv0, arv1, brv1}, 32'd0);
    chk("rst_run_rdata", ard0 | ard1, 32'h0);
    chk("rst_run_state", {29'b0, id0, ar0, br0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_pulse", {28'b0, arv0, brv0, arv1, brv1}, 32'd0);
    end
    rst = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_clear_busy", {31'b0, id0}, 32'd0);
    rst = 0;
    tick();
    chk("mid_clear_rst", {28'b0, arv0, brv0, id0, ar0}, 32'd0);
    rst = 1;
    measure_init(n0, n1);
    chk("restart_cycles_d16", n0, 32'd16);
    chk("restart_cycles_d12", n1, 32'd12);
    a_rd(4'd13); tick();
    chk("restart_clr_13", ard0, 32'h0);
    a_rd(4'd5); tick();
    chk("restart_clr_5", ard0, 32'h0);
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
